// File: rtl/plusarg_value_writer.sv
// Reports one WIDTH-bit value per input handshake as an ASCII record
// "<PREFIX><hex digits>\n" over a byte-wide valid/ready stream.
module plusarg_value_writer #(
    parameter int WIDTH      = 32,
    parameter int PREFIX_LEN = 4,
    parameter logic [8*((PREFIX_LEN > 0) ? PREFIX_LEN : 1)-1:0] PREFIX = "val="
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_bits,
    output logic             busy
);
    localparam int DIGITS = (WIDTH + 3) / 4;
    localparam int VW     = 4 * DIGITS;
    localparam int PW     = 8 * ((PREFIX_LEN > 0) ? PREFIX_LEN : 1);
    localparam int MAXC   = (PREFIX_LEN > DIGITS) ? PREFIX_LEN : DIGITS;
    localparam int CW     = $clog2(MAXC + 1);
    localparam logic [CW-1:0] LAST_P = CW'((PREFIX_LEN > 0) ? PREFIX_LEN - 1 : 0);
    localparam logic [CW-1:0] LAST_D = CW'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_DIGIT, S_EOL} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [VW-1:0]   r_value;
    logic            r_out_valid;
    logic [7:0]      r_out_bits;
    logic            r_rst_done;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [VW-1:0]   w_value_nxt;
    logic            w_valid_nxt;
    logic            w_load;
    logic [7:0]      w_bits_nxt;
    logic            w_hs;
    logic            w_accept;

    // Byte presented in state s at index c; evaluated on the next-state values
    // so every output byte is registered at the moment the index advances.
    function automatic logic [7:0] byte_for(input state_t s, input logic [CW-1:0] c,
                                            input logic [VW-1:0] v);
        logic [7:0]    b;
        logic [PW-1:0] psh;
        logic [VW-1:0] vsh;
        logic [3:0]    nib;
        int            idx;
        b   = 8'h00;
        psh = '0;
        vsh = '0;
        nib = 4'h0;
        idx = 0;
        case (s)
            S_PREFIX: begin
                idx = PREFIX_LEN - 1 - int'(c);
                if (idx >= 0) psh = PREFIX >> (8 * idx);
                b = psh[7:0];
            end
            S_DIGIT: begin
                idx = DIGITS - 1 - int'(c);
                if (idx >= 0) vsh = v >> (4 * idx);
                nib = vsh[3:0];
                b = (nib <= 4'd9) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
            end
            S_EOL:   b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign in_ready  = (r_state == S_IDLE) && r_rst_done;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_bits  = r_out_bits;
    assign w_hs      = r_out_valid && out_ready;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_value_nxt = r_value;
        w_valid_nxt = r_out_valid;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_value_nxt = VW'(in_bits);
                w_state_nxt = (PREFIX_LEN > 0) ? S_PREFIX : S_DIGIT;
                w_cnt_nxt   = '0;
                w_valid_nxt = 1'b1;
                w_load      = 1'b1;
            end
            S_PREFIX: if (w_hs) begin
                w_load = 1'b1;
                if (r_cnt == LAST_P) begin
                    w_state_nxt = S_DIGIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DIGIT: if (w_hs) begin
                w_load = 1'b1;
                if (r_cnt == LAST_D) begin
                    w_state_nxt = S_EOL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_EOL: if (w_hs) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_bits_nxt = w_load ? byte_for(w_state_nxt, w_cnt_nxt, w_value_nxt) : r_out_bits;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_value     <= '0;
            r_out_valid <= 1'b0;
            r_out_bits  <= 8'h00;
            r_rst_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_value     <= w_value_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_bits  <= w_bits_nxt;
            r_rst_done  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_plusarg_value_writer.sv
// Bench for plusarg_value_writer: three configurations (32-bit "val=", 10-bit
// no prefix, 1-bit "x") checked byte-by-byte against an expected queue.
module tb_plusarg_value_writer;
    // valid/ready: a byte or value transfers on a rising edge where both are 1.
    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       in_valid_v = '0;
    logic [2:0]       in_ready_v;
    logic [2:0][31:0] in_bits_a = '0;
    logic [2:0]       out_valid_v;
    logic [2:0]       out_ready_v = '0;
    logic [2:0][7:0]  out_bits_v;
    logic [2:0]       busy_v;

    int               tests = 0;
    int               fails = 0;
    int               cyc = 0;
    int               rmode[3] = '{0, 0, 0};
    int               rcnt = 0;
    logic [7:0]       exp_q[3][$];
    logic [2:0]       stall = '0;
    logic [2:0][7:0]  held = '0;

    typedef struct {
        logic [31:0]  val;
        int           mode;
        logic [127:0] str;
    } vec_t;
    vec_t vecs[6];

    plusarg_value_writer #(.WIDTH(32), .PREFIX_LEN(4), .PREFIX("val=")) d0 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_bits(in_bits_a[0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out_bits(out_bits_v[0]), .busy(busy_v[0]));
    plusarg_value_writer #(.WIDTH(10), .PREFIX_LEN(0), .PREFIX(8'h00)) d1 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_bits(in_bits_a[1][9:0]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out_bits(out_bits_v[1]), .busy(busy_v[1]));
    plusarg_value_writer #(.WIDTH(1), .PREFIX_LEN(1), .PREFIX("x")) d2 (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_bits(in_bits_a[2][0:0]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .out_bits(out_bits_v[2]), .busy(busy_v[2]));

    // Clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Sink ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random
    always @(posedge clock) begin
        #1;
        rcnt = rcnt + 1;
        for (int i = 0; i < 3; i++) begin
            case (rmode[i])
                0:       out_ready_v[i] = 1'b1;
                1:       out_ready_v[i] = (rcnt % 4 == 0) || (rcnt % 4 == 3);
                default: out_ready_v[i] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard monitor: inputs/outputs settle at posedge+1, checked at negedge
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_n) begin
                stall[i] = 1'b0;
            end else begin
                if (stall[i]) begin
                    tests++;
                    if (!out_valid_v[i] || out_bits_v[i] != held[i]) begin
                        fails++;
                        $display("FAIL stall_hold dut%0d: valid=%0b bits=%h, required valid=1 bits=%h",
                                 i, out_valid_v[i], out_bits_v[i], held[i]);
                    end
                end
                if (out_valid_v[i] && out_ready_v[i]) begin
                    tests++;
                    if (exp_q[i].size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_byte dut%0d: got %h, required none", i, out_bits_v[i]);
                    end else begin
                        logic [7:0] e;
                        e = exp_q[i].pop_front();
                        if (out_bits_v[i] != e) begin
                            fails++;
                            $display("FAIL byte dut%0d: got %h, required %h", i, out_bits_v[i], e);
                        end
                    end
                end
                stall[i] = out_valid_v[i] && !out_ready_v[i];
                held[i]  = out_bits_v[i];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push_str(input int i, input logic [127:0] s, input int len);
        for (int k = 0; k < len; k++) exp_q[i].push_back(s[8*(len-k)-1 -: 8]);
    endtask

    // Offer v to dut i, wait (bounded) for in_ready, push the expected record
    task automatic send(input int i, input logic [31:0] v, input logic [127:0] s,
                        input int len, output int acc_cyc);
        int w;
        w = 0;
        acc_cyc = -1;
        in_valid_v[i] = 1'b1;
        in_bits_a[i]  = v;
        while (!in_ready_v[i] && w < 200) begin
            @(posedge clock); #1;
            w++;
        end
        if (!in_ready_v[i]) begin
            tests++;
            fails++;
            $display("FAIL send_timeout dut%0d: in_ready stayed 0, required 1", i);
            in_valid_v[i] = 1'b0;
        end else begin
            push_str(i, s, len);
            @(posedge clock); #1;
            acc_cyc = cyc;
            in_valid_v[i] = 1'b0;
        end
    endtask

    task automatic wait_drain(input int i);
        int n;
        n = 0;
        while ((exp_q[i].size() != 0 || busy_v[i]) && n < 500) begin
            @(posedge clock); #1;
            n++;
        end
        check($sformatf("drain_dut%0d", i), 32'(n < 500), 32'd1);
    endtask

    initial begin
        int a1, a2, n;
        vecs[0].val = 32'h0000002A; vecs[0].mode = 0; vecs[0].str = "val=0000002A\n";
        vecs[1].val = 32'hDEADBEEF; vecs[1].mode = 1; vecs[1].str = "val=DEADBEEF\n";
        vecs[2].val = 32'hFFFFFFFF; vecs[2].mode = 2; vecs[2].str = "val=FFFFFFFF\n";
        vecs[3].val = 32'h00000000; vecs[3].mode = 0; vecs[3].str = "val=00000000\n";
        vecs[4].val = 32'h9ABCDEF0; vecs[4].mode = 2; vecs[4].str = "val=9ABCDEF0\n";
        vecs[5].val = 32'h01234567; vecs[5].mode = 1; vecs[5].str = "val=01234567\n";

        // Reset state
        #13;
        check("rst_in_ready", 32'(in_ready_v), 32'h0);
        check("rst_out_valid", 32'(out_valid_v), 32'h0);
        check("rst_busy", 32'(busy_v), 32'h0);
        check("rst_out_bits", 32'(out_bits_v), 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        check("ready_before_first_edge", 32'(in_ready_v), 32'h0);
        @(posedge clock); #1;
        check("ready_after_first_edge", 32'(in_ready_v), 32'h7);

        // Latency and record period with out_ready held high
        send(0, 32'h0000002A, "val=0000002A\n", 13, a1);
        check("first_byte_latency", 32'(out_valid_v[0]), 32'd1);
        check("first_byte_value", 32'(out_bits_v[0]), 32'h76);
        n = 0;
        while (!in_ready_v[0] && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("ready_return_edges", 32'(n), 32'd13);
        wait_drain(0);

        // Table-driven records
        foreach (vecs[k]) begin
            rmode[0] = vecs[k].mode;
            send(0, vecs[k].val, vecs[k].str, 13, a1);
            wait_drain(0);
        end
        rmode[0] = 0;

        // in_valid held high with in_bits changing mid-record
        in_valid_v[0] = 1'b1;
        in_bits_a[0]  = 32'h1;
        check("held_ready_idle", 32'(in_ready_v[0]), 32'd1);
        push_str(0, "val=00000001\n", 13);
        @(posedge clock); #1;
        in_bits_a[0] = 32'h2;
        n = 0;
        while (!in_ready_v[0] && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("held_ready_low_edges", 32'(n), 32'd13);
        push_str(0, "val=00000002\n", 13);
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        check("held_second_accepted", 32'(busy_v[0]), 32'd1);
        wait_drain(0);

        // Reset pulsed during the third digit of 12345678
        send(0, 32'h12345678, "val=12345678\n", 13, a1);
        n = 0;
        while (!(out_valid_v[0] && out_bits_v[0] == 8'h33) && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("third_digit_seen", 32'(n < 50), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid_v[0]), 32'd0);
        check("midrst_busy", 32'(busy_v[0]), 32'd0);
        check("midrst_in_ready", 32'(in_ready_v[0]), 32'd0);
        exp_q[0].delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        send(0, 32'h9, "val=00000009\n", 13, a1);
        wait_drain(0);

        // 10-bit, no prefix
        rmode[1] = 0;
        send(1, 32'h3FF, "3FF\n", 4, a1);
        wait_drain(1);
        rmode[1] = 1;
        send(1, 32'h005, "005\n", 4, a1);
        wait_drain(1);
        rmode[1] = 2;
        send(1, 32'h2A0, "2A0\n", 4, a1);
        wait_drain(1);

        // 1-bit, prefix "x", back-to-back values
        rmode[2] = 0;
        send(2, 32'h1, "x1\n", 3, a1);
        send(2, 32'h0, "x0\n", 3, a2);
        check("x_period", 32'(a2 - a1), 32'd4);
        wait_drain(2);

        for (int i = 0; i < 3; i++) check($sformatf("queue_empty_dut%0d", i), 32'(exp_q[i].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
